// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: two-requester round-robin arbiter feeding a saturating fixed-point adder with a one-entry result register
module fp_add_arbiter #(
   parameter int W_in   = 16,
   parameter int W_in_F = 14
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0_valid,
   input  logic [W_in-1:0] req0_a,
   input  logic [W_in-1:0] req0_b,
   output logic            req0_ready,
   input  logic            req1_valid,
   input  logic [W_in-1:0] req1_a,
   input  logic [W_in-1:0] req1_b,
   output logic            req1_ready,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [W_in-1:0] res_sum,
   output logic            res_id,
   output logic            res_overflow,
   output logic            res_underflow
);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t          state;
   logic            last_grant;
   logic            can_accept;
   logic            grant0;
   logic            grant1;
   logic            accept;
   logic [W_in-1:0] a;
   logic [W_in-1:0] b;
   logic [W_in:0]   s;
   logic            ovf;
   logic            unf;

   // Operands and result share one binary point, so the format only has to leave room for a sign bit
   if (W_in_F >= W_in) begin : g_fmt_check
      $error("fp_add_arbiter: W_in_F must be smaller than W_in");
   end

   assign res_valid = state == FULL;

   // Round-robin grant, ready gating and the sign-extended saturating sum of the granted pair
   always_comb begin
      can_accept = state == EMPTY || res_ready;
      grant0     = req0_valid && (!req1_valid || last_grant);
      grant1     = req1_valid && (!req0_valid || !last_grant);
      req0_ready = grant0 && can_accept && !rst;
      req1_ready = grant1 && can_accept && !rst;
      accept     = req0_ready || req1_ready;
      a          = req1_ready ? req1_a : req0_a;
      b          = req1_ready ? req1_b : req0_b;
      s          = {a[W_in-1], a} + {b[W_in-1], b};
      ovf        = !s[W_in] && s[W_in-1];
      unf        = s[W_in] && !s[W_in-1];
   end

   // Output FSM and result register: load on accept, empty on a drain with nothing new
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= EMPTY;
         last_grant    <= 1'b1;
         res_sum       <= '0;
         res_id        <= 1'b0;
         res_overflow  <= 1'b0;
         res_underflow <= 1'b0;
      end else if (accept) begin
         state         <= FULL;
         last_grant    <= req1_ready;
         res_id        <= req1_ready;
         res_overflow  <= ovf;
         res_underflow <= unf;
         res_sum       <= ovf ? {1'b0, {(W_in-1){1'b1}}} : unf ? {1'b1, {(W_in-1){1'b0}}} : s[W_in-1:0];
      end else if (res_ready) begin
         state <= EMPTY;
      end
   end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: directed scenario tests for the arbitrated saturating adder
module tb_fp_add_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid = 1'b0;
   logic [15:0] req0_a = '0;
   logic [15:0] req0_b = '0;
   logic        req0_ready;
   logic        req1_valid = 1'b0;
   logic [15:0] req1_a = '0;
   logic [15:0] req1_b = '0;
   logic        req1_ready;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [15:0] res_sum;
   logic        res_id;
   logic        res_overflow;
   logic        res_underflow;
   int          checks = 0;
   int          errors = 0;

   fp_add_arbiter #(.W_in(16), .W_in_F(14)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_id(res_id),
      .res_overflow(res_overflow), .res_underflow(res_underflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      res_ready  = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         errors++;
         $display("FAIL reset_readies: got %b expected 00", {req0_ready, req1_ready});
      end
      checks++;
      if ({res_valid, res_sum, res_id, res_overflow, res_underflow} !== 20'h0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b sum=%h id=%b ovf=%b unf=%b expected all 0",
                  res_valid, res_sum, res_id, res_overflow, res_underflow);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_basic_add();
      req0_valid = 1'b1;
      req0_a = 16'h2000;
      req0_b = 16'h9000;
      res_ready = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++;
         $display("FAIL basic_ready: got %b expected 10", {req0_ready, req1_ready});
      end
      tick();
      req0_valid = 1'b0;
      checks++;
      if ({res_valid, res_sum, res_id, res_overflow, res_underflow} !== {1'b1, 16'hB000, 3'b000}) begin
         errors++;
         $display("FAIL basic_add: got valid=%b sum=%h id=%b ovf=%b unf=%b expected 1 b000 0 0 0",
                  res_valid, res_sum, res_id, res_overflow, res_underflow);
      end
      tick();
      checks++;
      if (res_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_drain: res_valid got %b expected 0", res_valid);
      end
   endtask

   task automatic test_overflow();
      req1_valid = 1'b1;
      req1_a = 16'h5555;
      req1_b = 16'h4000;
      tick();
      req1_valid = 1'b0;
      checks++;
      if ({res_valid, res_sum, res_id, res_overflow, res_underflow} !== {1'b1, 16'h7FFF, 3'b110}) begin
         errors++;
         $display("FAIL overflow: got valid=%b sum=%h id=%b ovf=%b unf=%b expected 1 7fff 1 1 0",
                  res_valid, res_sum, res_id, res_overflow, res_underflow);
      end
      tick();
   endtask

   task automatic test_underflow();
      req0_valid = 1'b1;
      req0_a = 16'hF777;
      req0_b = 16'h8001;
      tick();
      req0_valid = 1'b0;
      checks++;
      if ({res_valid, res_sum, res_id, res_overflow, res_underflow} !== {1'b1, 16'h8000, 3'b001}) begin
         errors++;
         $display("FAIL underflow: got valid=%b sum=%h id=%b ovf=%b unf=%b expected 1 8000 0 0 1",
                  res_valid, res_sum, res_id, res_overflow, res_underflow);
      end
      tick();
   endtask

   task automatic test_contention();
      logic [15:0] exp_sum;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req0_a = 16'h0100;
      req0_b = 16'h0001;
      req1_a = 16'h0200;
      req1_b = 16'h0002;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      res_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL contention_ready[%0d]: got %b expected %b", i, {req0_ready, req1_ready},
                     (i % 2 == 0) ? 2'b10 : 2'b01);
         end
         @(posedge clk);
         #1;
         exp_sum = (i % 2 == 0) ? 16'h0101 : 16'h0202;
         checks++;
         if ({res_valid, res_id, res_sum} !== {1'b1, i[0], exp_sum}) begin
            errors++;
            $display("FAIL contention_result[%0d]: got valid=%b id=%b sum=%h expected 1 %b %h",
                     i, res_valid, res_id, res_sum, i[0], exp_sum);
         end
      end
   endtask

   task automatic test_backpressure();
      res_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL stall_ready[%0d]: got %b expected 00", i, {req0_ready, req1_ready});
         end
         tick();
         checks++;
         if ({res_valid, res_id, res_sum, res_overflow, res_underflow} !== {1'b1, 1'b1, 16'h0202, 2'b00}) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got valid=%b id=%b sum=%h expected 1 1 0202", i, res_valid, res_id, res_sum);
         end
      end
      res_ready = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++;
         $display("FAIL release_ready: got %b expected 10", {req0_ready, req1_ready});
      end
      tick();
      checks++;
      if ({res_valid, res_id, res_sum} !== {1'b1, 1'b0, 16'h0101}) begin
         errors++;
         $display("FAIL release_result: got valid=%b id=%b sum=%h expected 1 0 0101", res_valid, res_id, res_sum);
      end
   endtask

   task automatic test_reset_mid();
      tick();
      checks++;
      if ({res_valid, res_id} !== 2'b11) begin
         errors++;
         $display("FAIL pre_reset_full: got valid=%b id=%b expected 1 1", res_valid, res_id);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({res_valid, res_sum, res_id, res_overflow, res_underflow} !== 20'h0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got valid=%b sum=%h id=%b ovf=%b unf=%b expected all 0",
                  res_valid, res_sum, res_id, res_overflow, res_underflow);
      end
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++;
         $display("FAIL post_reset_ready: got %b expected 10", {req0_ready, req1_ready});
      end
      tick();
      checks++;
      if ({res_valid, res_id, res_sum} !== {1'b1, 1'b0, 16'h0101}) begin
         errors++;
         $display("FAIL post_reset_first: got valid=%b id=%b sum=%h expected 1 0 0101", res_valid, res_id, res_sum);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();
      checks++;
      if (res_valid !== 1'b0) begin
         errors++;
         $display("FAIL final_drain: res_valid got %b expected 0", res_valid);
      end
   endtask

   initial begin
      test_reset();
      test_basic_add();
      test_overflow();
      test_underflow();
      test_contention();
      test_backpressure();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
